conv5_fmap_writer: RTL and testbench
====================================

# conv5_fmap_writer

Producer side of the layer-5 → layer-6 feature-map buffer. Accepts the conv-5 accumulator stream, rounds, shifts, ReLU-clamps and saturates each value to 8 bits, and writes the 8×8 map into an internal buffer in raster order. It exposes the read port that the layer-6 max-pool consumer drives, plus the `conv_5_ready` and `conv_5_write_complete` handshakes that consumer waits on.

## Interface
Parameters:
- `FMAP_W`, 8, map width (row pitch).
- `FMAP_H`, 8, map height; depth = `FMAP_W*FMAP_H` = 64.
- `ACC_W`, 16, signed accumulator width.
- `SHIFT`, 6, requantization right shift, ≥1.
- `LEAD`, 16, minimum number of written entries ahead of the consumer's read address before `conv_5_ready` asserts.
- `ADDR_W`, 7, address width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `layer_5_write_begin` in 1: single-cycle start/restart pulse.
- `acc_valid` in 1: accumulator sample valid this cycle.
- `acc_in` in `ACC_W`: signed accumulator.
- `rd_en` in 1: consumer read enable.
- `rd_addr` in `ADDR_W`: consumer read address.
- `rd_data` out 8: registered read data.
- `conv_5_ready` out 1: consumer may advance.
- `conv_5_write_complete` out 1: all 64 entries written.
- `wr_addr` out `ADDR_W`: next write address, equal to the write count.
- `overflow_err` out 1: sticky; a sample arrived in DONE.

## Operation
- States:
  - IDLE: `acc_valid` is ignored.
  - FILL: each `acc_valid` writes `mem[wr_addr]` and increments `wr_addr`.
  - DONE: entered on the cycle after write 64 (`wr_addr` = 64).
- Transitions:
  - `layer_5_write_begin` in any state → FILL. Clears `wr_addr`, `conv_5_ready`, `conv_5_write_complete` and `overflow_err`.
  - If begin and `acc_valid` occur in the same cycle, begin wins and the sample is dropped.
  - FILL → DONE on the 64th write.
  - DONE holds until the next begin.
  - `acc_valid` in DONE sets `overflow_err`; memory is unchanged.
- Requantization, combinational on `acc_in`:
  - t = `acc_in` + 2^(`SHIFT`−1), computed in `ACC_W`+1 bits signed.
  - y = t >>> `SHIFT`.
  - Output is 0 if y < 0, 255 if y > 255, otherwise y[7:0].
- `conv_5_ready` (registered):
  - In FILL: 1 iff `wr_addr` ≥ `rd_addr` + `LEAD`. The comparison uses `ADDR_W`+1 bits with no wrap.
  - In DONE: 1.
  - In IDLE: 0.
- `conv_5_write_complete` = (state == DONE), registered.
- Read port:
  - `rd_en`=1 → `rd_data` = `mem[rd_addr]` on the next edge.
  - `rd_en`=0 → `rd_data` holds.
  - Addresses ≥ 64 return 0.
  - Read-first: reading an address in the same cycle it is written returns the old content.
- Reset value of every output is 0; state resets to IDLE. Memory contents are not reset.
- Reset mid-FILL aborts the frame; `conv_5_write_complete` stays 0 until a fresh begin and 64 new writes.

## Timing
- Write latency: the sample at edge N is readable with `rd_en` at edge N+1, and data appears at N+2.
- `wr_addr` increments at the same edge that captures the sample.
- `conv_5_ready` reflects `wr_addr`/`rd_addr` sampled at edge N, visible after edge N.
- `conv_5_write_complete` rises one cycle after the 64th write and is level-held.
- The consumer holds in its wait state while `conv_5_ready`=0. `LEAD` = 2·`FMAP_W` guarantees the consumer never reads an unwritten address with one cycle of ready latency.
- Throughput: one sample per cycle, with no backpressure on the accumulator side.

## Structure
- Shared package `cnn_pkg`: `FMAP_W`, `FMAP_H`, `ACC_W`, depth constant, state enum (IDLE/FILL/DONE).
- Sub-module `fmap_ram_sdp`: simple dual-port, one write port and one registered read port, read-first, 64×8, without reset.
- The requantize/clamp logic stays inline.

## Test plan
- Reset: assert `rst` for 2 cycles with `acc_valid`=1 → all outputs 0, `wr_addr`=0, no writes.
- Requantization with `SHIFT`=6, using begin then acc 100, −100, 95, 96, 32767, −32768 → `mem[0..5]` = 2, 0, 1, 2, 255, 0.
- Ready threshold with `rd_addr`=0: after 15 writes `conv_5_ready`=0; the 16th write makes it 1 the next cycle. Then set `rd_addr`=8 → ready=0 until `wr_addr`=24.
- Completion: 64 back-to-back writes → `conv_5_write_complete`=1 one cycle after the last. A 65th `acc_valid` → `overflow_err`=1 and `mem[63]` is unchanged.
- Restart: begin at `wr_addr`=30 → `wr_addr`=0, ready=0, complete=0. Then 64 writes complete normally, and begin together with `acc_valid` drops that sample.
- Collision: write 7 to addr 10, then write 9 to addr 10 with `rd_en`, `rd_addr`=10 in the same cycle → `rd_data`=7; a read on the next cycle → 9.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN feature-map pipeline.
package cnn_pkg;

  localparam int unsigned FMAP_W     = 8;
  localparam int unsigned FMAP_H     = 8;
  localparam int unsigned ACC_W      = 16;
  localparam int unsigned FMAP_DEPTH = FMAP_W * FMAP_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fmap_ram_sdp.sv
// Simple dual-port feature-map RAM: one write port, one registered read-first read port.
module fmap_ram_sdp #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array storage carries no reset; the writer only ever presents in-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
    end
  end

  // Out-of-range reads return zero; a same-cycle write is not yet visible (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (rd_addr_i < ADDR_W'(DEPTH)) ? mem[rd_addr_i[IDX_W-1:0]] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv5_fmap_writer.sv
// Conv-5 producer: requantizes the accumulator stream into an 8x8 map buffer and
// exposes the read port plus ready/complete handshakes for the layer-6 consumer.
module conv5_fmap_writer #(
  parameter int unsigned FMAP_W = cnn_pkg::FMAP_W,
  parameter int unsigned FMAP_H = cnn_pkg::FMAP_H,
  parameter int unsigned ACC_W  = cnn_pkg::ACC_W,
  parameter int unsigned SHIFT  = 6,
  parameter int unsigned LEAD   = 16,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    layer_5_write_begin,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [7:0]              rd_data,
  output logic                    conv_5_ready,
  output logic                    conv_5_write_complete,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    overflow_err
);

  import cnn_pkg::*;

  localparam int unsigned DEPTH = FMAP_W * FMAP_H;
  localparam int unsigned T_W   = ACC_W + 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              ready_q, ready_d;
  logic              complete_q, complete_d;
  logic              overflow_q, overflow_d;
  logic              wr_en_c;

  logic signed [T_W-1:0] t_c;
  logic signed [T_W-1:0] y_c;
  logic [7:0]            q_c;

  // Round-half-up, arithmetic shift, then ReLU clamp and saturate to 8 bits.
  always_comb begin
    t_c = $signed({acc_in[ACC_W-1], acc_in}) + $signed(T_W'(1) << (SHIFT - 1));
    y_c = t_c >>> SHIFT;
    q_c = y_c[7:0];
    if (y_c[T_W-1]) begin
      q_c = 8'd0;
    end else if (y_c[T_W-2:8] != '0) begin
      q_c = 8'd255;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Begin always restarts a frame and outranks any same-cycle sample.
  always_comb begin
    state_d = state_q;
    if (layer_5_write_begin) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (acc_valid && (wr_addr_q == ADDR_W'(DEPTH - 1))) begin
            state_d = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    wr_en_c    = 1'b0;
    wr_addr_d  = wr_addr_q;
    ready_d    = 1'b0;
    complete_d = 1'b0;
    overflow_d = overflow_q;
    if (layer_5_write_begin) begin
      wr_addr_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          wr_en_c = acc_valid;
          if (acc_valid) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
          ready_d = ({1'b0, wr_addr_q} >= ({1'b0, rd_addr} + CMP_W'(LEAD)));
        end
        DONE: begin
          ready_d    = 1'b1;
          complete_d = 1'b1;
          overflow_d = overflow_q | acc_valid;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      ready_q    <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      ready_q    <= ready_d;
      complete_q <= complete_d;
      overflow_q <= overflow_d;
    end
  end

  fmap_ram_sdp #(
    .DEPTH  (DEPTH),
    .DATA_W (8),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (q_c),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign conv_5_ready          = ready_q;
  assign conv_5_write_complete = complete_q;
  assign wr_addr               = wr_addr_q;
  assign overflow_err          = overflow_q;

endmodule

// File: tb/tb_conv5_fmap_writer.sv
// Directed bench for conv5_fmap_writer: requantization table plus handshake/corner sequences.
module tb_conv5_fmap_writer;

  logic               clk;
  logic               rst;
  logic               layer_5_write_begin;
  logic               acc_valid;
  logic signed [15:0] acc_in;
  logic               rd_en;
  logic [6:0]         rd_addr;
  logic [7:0]         rd_data;
  logic               conv_5_ready;
  logic               conv_5_write_complete;
  logic [6:0]         wr_addr;
  logic               overflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [15:0] acc;
    logic [7:0]         exp;
  } rq_vec_t;

  rq_vec_t vecs [10];

  conv5_fmap_writer dut (
    .clk                   (clk),
    .rst                   (rst),
    .layer_5_write_begin   (layer_5_write_begin),
    .acc_valid             (acc_valid),
    .acc_in                (acc_in),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .rd_data               (rd_data),
    .conv_5_ready          (conv_5_ready),
    .conv_5_write_complete (conv_5_write_complete),
    .wr_addr               (wr_addr),
    .overflow_err          (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_begin();
    layer_5_write_begin = 1'b1;
    step();
    layer_5_write_begin = 1'b0;
  endtask

  // Back-to-back samples whose requantized value is (base+i).
  task automatic write_burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      acc_valid = 1'b1;
      acc_in    = 16'((base + i) * 64);
      step();
    end
    acc_valid = 1'b0;
  endtask

  task automatic rd(input int addr, output int data);
    rd_en   = 1'b1;
    rd_addr = 7'(addr);
    step();
    rd_en   = 1'b0;
    data    = int'(rd_data);
  endtask

  initial begin
    int d;
    int budget;

    vecs[0] = '{16'(100),    8'd2};
    vecs[1] = '{16'(-100),   8'd0};
    vecs[2] = '{16'(95),     8'd1};
    vecs[3] = '{16'(96),     8'd2};
    vecs[4] = '{16'(32767),  8'd255};
    vecs[5] = '{16'(-32768), 8'd0};
    vecs[6] = '{16'(16287),  8'd254};
    vecs[7] = '{16'(16352),  8'd255};
    vecs[8] = '{16'(32),     8'd1};
    vecs[9] = '{16'(-33),    8'd0};

    rst                 = 1'b1;
    layer_5_write_begin = 1'b0;
    acc_valid           = 1'b1;
    acc_in              = 16'(100);
    rd_en               = 1'b0;
    rd_addr             = 7'd0;

    // Reset held two cycles with samples presented.
    step();
    step();
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_ready", int'(conv_5_ready), 0);
    check("rst_complete", int'(conv_5_write_complete), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_overflow", int'(overflow_err), 0);
    rst = 1'b0;
    step();
    check("idle_ignores_valid", int'(wr_addr), 0);
    acc_valid = 1'b0;

    // Requantization table.
    pulse_begin();
    for (int i = 0; i < 10; i++) begin
      acc_valid = 1'b1;
      acc_in    = vecs[i].acc;
      step();
    end
    acc_valid = 1'b0;
    check("rq_wr_addr", int'(wr_addr), 10);
    for (int i = 0; i < 10; i++) begin
      rd(i, d);
      check($sformatf("rq_mem%0d", i), d, int'(vecs[i].exp));
    end

    // Ready threshold.
    rd_addr = 7'd0;
    pulse_begin();
    check("begin_ready", int'(conv_5_ready), 0);
    write_burst(0, 15);
    step();
    check("ready_after_15", int'(conv_5_ready), 0);
    write_burst(15, 1);
    check("ready_at_16th_edge", int'(conv_5_ready), 0);
    step();
    check("ready_after_16", int'(conv_5_ready), 1);
    rd_addr = 7'd8;
    step();
    check("ready_rd8_wr16", int'(conv_5_ready), 0);
    write_burst(16, 7);
    step();
    check("ready_rd8_wr23", int'(conv_5_ready), 0);
    write_burst(23, 1);
    check("wr_addr_24", int'(wr_addr), 24);
    step();
    check("ready_rd8_wr24", int'(conv_5_ready), 1);

    // Completion and overflow.
    rd_addr = 7'd0;
    pulse_begin();
    write_burst(0, 64);
    check("full_wr_addr", int'(wr_addr), 64);
    check("complete_at_last_edge", int'(conv_5_write_complete), 0);
    step();
    check("complete_after_last", int'(conv_5_write_complete), 1);
    check("ready_in_done", int'(conv_5_ready), 1);
    check("no_overflow_yet", int'(overflow_err), 0);
    acc_valid = 1'b1;
    acc_in    = 16'sh7fff;
    step();
    acc_valid = 1'b0;
    check("overflow_set", int'(overflow_err), 1);
    check("done_wr_addr_hold", int'(wr_addr), 64);
    rd(63, d);
    check("mem63_unchanged", d, 63);
    rd(10, d);
    check("mem10", d, 10);
    rd(64, d);
    check("oob_read64", d, 0);
    rd(127, d);
    check("oob_read127", d, 0);
    step();
    check("overflow_sticky", int'(overflow_err), 1);

    // Restart mid-frame.
    pulse_begin();
    check("begin_clears_overflow", int'(overflow_err), 0);
    write_burst(0, 30);
    check("restart_wr_addr_30", int'(wr_addr), 30);
    pulse_begin();
    check("restart_wr_addr", int'(wr_addr), 0);
    check("restart_ready", int'(conv_5_ready), 0);
    check("restart_complete", int'(conv_5_write_complete), 0);
    write_burst(100, 64);
    budget = 0;
    while (!conv_5_write_complete && budget < 5) begin
      step();
      budget++;
    end
    check("restart_complete_wait", int'(conv_5_write_complete), 1);
    layer_5_write_begin = 1'b1;
    acc_valid           = 1'b1;
    acc_in              = 16'(5 * 64);
    step();
    layer_5_write_begin = 1'b0;
    acc_valid           = 1'b0;
    check("begin_wins_wr_addr", int'(wr_addr), 0);
    check("begin_wins_overflow", int'(overflow_err), 0);
    rd(0, d);
    check("begin_wins_mem0", d, 100);

    // Read-first collision on address 10.
    pulse_begin();
    write_burst(0, 10);
    write_burst(7, 1);
    pulse_begin();
    write_burst(0, 10);
    acc_valid = 1'b1;
    acc_in    = 16'(9 * 64);
    rd_en     = 1'b1;
    rd_addr   = 7'd10;
    step();
    acc_valid = 1'b0;
    check("collision_old", int'(rd_data), 7);
    step();
    check("collision_new", int'(rd_data), 9);
    rd_en   = 1'b0;
    rd_addr = 7'd0;
    step();
    check("rd_hold", int'(rd_data), 9);

    // Reset mid-fill aborts the frame.
    rst = 1'b1;
    step();
    rst = 1'b0;
    write_burst(0, 3);
    check("abort_wr_addr", int'(wr_addr), 0);
    check("abort_complete", int'(conv_5_write_complete), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
